// File: rtl/iodelay_bitslip_align.sv
// Per-channel LVDS alignment engine: sweeps IODELAY taps, centres on the first data eye,
// then bitslips the ISERDES until the training word is seen. ALIGN_DEBUG_EN adds debug ports.
module iodelay_bitslip_align #(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       TAP_W      = 5,
  parameter int unsigned       NUM_TAPS   = 32,
  parameter int unsigned       SETTLE_CYC = 8,
  parameter int unsigned       CHECK_CYC  = 16,
  parameter logic [DATA_W-1:0] TRAIN_PAT  = 8'h2C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_align_i,
  input  logic [3:0]        chan_sel_i,
  input  logic [DATA_W-1:0] data_in_i,
  output logic              idelay_rst_o,
  output logic              idelay_ce_o,
  output logic              idelay_inc_o,
  output logic              bitslip_o,
  output logic [TAP_W-1:0]  tap_value_o,
  output logic              data_aligned_o,
  output logic              align_fail_o,
  output logic              busy_o,
  output logic [3:0]        active_chan_o
`ifdef ALIGN_DEBUG_EN
  ,
  output logic [TAP_W-1:0]  eye_start_o,
  output logic [TAP_W-1:0]  eye_end_o,
  output logic [3:0]        slip_cnt_o
`endif
);

  localparam int unsigned CntMax = (SETTLE_CYC > CHECK_CYC) ? SETTLE_CYC : CHECK_CYC;
  localparam int unsigned CntW   = $clog2(CntMax);

  localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0]  CheckLast  = CntW'(CHECK_CYC - 1);
  localparam logic [TAP_W-1:0] TapLast    = TAP_W'(NUM_TAPS - 1);
  localparam logic [3:0]       SlipMax    = 4'(DATA_W);

  typedef enum logic [3:0] {
    StIdle,
    StDlyRst,
    StSettle,
    StCheck,
    StStep,
    StCenter,
    StCenterStep,
    StSlipCheck,
    StDone,
    StFail
  } state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [TAP_W-1:0]  tap_q;
  logic [TAP_W-1:0]  center_q;
  logic [TAP_W-1:0]  eye_start_q;
  logic [TAP_W-1:0]  eye_end_q;
  logic              eye_found_q;
  logic              eye_closed_q;
  logic [DATA_W-1:0] first_q;
  logic              stable_q;
  logic              match_q;
  logic              slip_phase_q;
  logic              gap_q;
  logic [3:0]        slip_cnt_q;
  logic [3:0]        chan_q;
  logic              busy_q;
  logic              align_fail_q;
  logic              idelay_rst_q;
  logic              idelay_ce_q;
  logic              bitslip_q;
  logic              data_aligned_q;

`ifdef ALIGN_DEBUG_EN
  logic [TAP_W-1:0]  dbg_eye_start_q;
  logic [TAP_W-1:0]  dbg_eye_end_q;
  logic [3:0]        dbg_slip_cnt_q;
`endif

  logic [TAP_W:0]    eye_sum;
  logic [TAP_W-1:0]  centre;
  logic              word_eq;
  logic              stab_now;
  logic              pat_eq;

  // Sum is one bit wider so the floor average never overflows.
  assign eye_sum  = {1'b0, eye_start_q} + {1'b0, eye_end_q};
  assign centre   = eye_sum[TAP_W:1];
  assign word_eq  = (data_in_i == first_q);
  assign stab_now = stable_q & word_eq;
  assign pat_eq   = (data_in_i == TRAIN_PAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      tap_q          <= '0;
      center_q       <= '0;
      eye_start_q    <= '0;
      eye_end_q      <= '0;
      eye_found_q    <= 1'b0;
      eye_closed_q   <= 1'b0;
      first_q        <= '0;
      stable_q       <= 1'b0;
      match_q        <= 1'b0;
      slip_phase_q   <= 1'b0;
      gap_q          <= 1'b0;
      slip_cnt_q     <= '0;
      chan_q         <= '0;
      busy_q         <= 1'b0;
      align_fail_q   <= 1'b0;
      idelay_rst_q   <= 1'b0;
      idelay_ce_q    <= 1'b0;
      bitslip_q      <= 1'b0;
      data_aligned_q <= 1'b0;
`ifdef ALIGN_DEBUG_EN
      dbg_eye_start_q <= '0;
      dbg_eye_end_q   <= '0;
      dbg_slip_cnt_q  <= '0;
`endif
    end else begin
      idelay_rst_q   <= 1'b0;
      idelay_ce_q    <= 1'b0;
      bitslip_q      <= 1'b0;
      data_aligned_q <= 1'b0;
      // Busy covers the data_aligned cycle and drops on the one after it.
      if (data_aligned_q) busy_q <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start_align_i && !busy_q) begin
            chan_q       <= chan_sel_i;
            align_fail_q <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= StDlyRst;
          end
        end

        StDlyRst: begin
          idelay_rst_q <= 1'b1;
          tap_q        <= '0;
          eye_start_q  <= '0;
          eye_end_q    <= '0;
          eye_found_q  <= 1'b0;
          eye_closed_q <= 1'b0;
          slip_cnt_q   <= '0;
          slip_phase_q <= 1'b0;
          cnt_q        <= '0;
          state_q      <= StSettle;
        end

        StSettle: begin
          if (cnt_q == SettleLast) begin
            cnt_q   <= '0;
            state_q <= slip_phase_q ? StSlipCheck : StCheck;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StCheck: begin
          if (cnt_q == '0) begin
            first_q  <= data_in_i;
            stable_q <= 1'b1;
            cnt_q    <= cnt_q + CntW'(1);
          end else if (cnt_q == CheckLast) begin
            cnt_q   <= '0;
            state_q <= StStep;
            // Keep only the first eye; the first unstable tap after it closes the sweep.
            if (stab_now) begin
              if (!eye_found_q) begin
                eye_found_q <= 1'b1;
                eye_start_q <= tap_q;
                eye_end_q   <= tap_q;
              end else if (!eye_closed_q) begin
                eye_end_q <= tap_q;
              end
            end else if (eye_found_q) begin
              eye_closed_q <= 1'b1;
            end
          end else begin
            if (!word_eq) stable_q <= 1'b0;
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StStep: begin
          if ((tap_q != TapLast) && !eye_closed_q) begin
            idelay_ce_q <= 1'b1;
            tap_q       <= tap_q + TAP_W'(1);
            state_q     <= StSettle;
          end else begin
            state_q <= StCenter;
          end
        end

        StCenter: begin
          if (!eye_found_q) begin
            state_q <= StFail;
          end else begin
            idelay_rst_q <= 1'b1;
            tap_q        <= '0;
            center_q     <= centre;
            gap_q        <= 1'b1;
            state_q      <= StCenterStep;
          end
        end

        StCenterStep: begin
          if (tap_q == center_q) begin
            slip_phase_q <= 1'b1;
            cnt_q        <= '0;
            state_q      <= StSettle;
          end else if (gap_q) begin
            gap_q <= 1'b0;
          end else begin
            idelay_ce_q <= 1'b1;
            tap_q       <= tap_q + TAP_W'(1);
            gap_q       <= 1'b1;
          end
        end

        StSlipCheck: begin
          if (cnt_q == CheckLast) begin
            cnt_q <= '0;
            if (match_q && pat_eq) begin
              state_q <= StDone;
            end else if (slip_cnt_q < SlipMax) begin
              bitslip_q  <= 1'b1;
              slip_cnt_q <= slip_cnt_q + 4'd1;
              state_q    <= StSettle;
            end else begin
              state_q <= StFail;
            end
          end else begin
            match_q <= (cnt_q == '0) ? pat_eq : (match_q & pat_eq);
            cnt_q   <= cnt_q + CntW'(1);
          end
        end

        StDone: begin
          data_aligned_q <= 1'b1;
          state_q        <= StIdle;
`ifdef ALIGN_DEBUG_EN
          dbg_eye_start_q <= eye_start_q;
          dbg_eye_end_q   <= eye_end_q;
          dbg_slip_cnt_q  <= slip_cnt_q;
`endif
        end

        StFail: begin
          align_fail_q   <= 1'b1;
          data_aligned_q <= 1'b1;
          state_q        <= StIdle;
`ifdef ALIGN_DEBUG_EN
          dbg_eye_start_q <= eye_start_q;
          dbg_eye_end_q   <= eye_end_q;
          dbg_slip_cnt_q  <= slip_cnt_q;
`endif
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign idelay_rst_o   = idelay_rst_q;
  assign idelay_ce_o    = idelay_ce_q;
  assign idelay_inc_o   = 1'b1;
  assign bitslip_o      = bitslip_q;
  assign tap_value_o    = tap_q;
  assign data_aligned_o = data_aligned_q;
  assign align_fail_o   = align_fail_q;
  assign busy_o         = busy_q;
  assign active_chan_o  = chan_q;

`ifdef ALIGN_DEBUG_EN
  assign eye_start_o = dbg_eye_start_q;
  assign eye_end_o   = dbg_eye_end_q;
  assign slip_cnt_o  = dbg_slip_cnt_q;
`endif

endmodule

// File: tb/tb_iodelay_bitslip_align.sv
// Bench for iodelay_bitslip_align: a channel model reacts to IODELAY/bitslip pulses and a
// scoreboard compares each data_aligned completion against hand-computed results.
module tb_iodelay_bitslip_align;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_align = 1'b0;
  logic [3:0] chan_sel = 4'd0;
  logic [7:0] data_in = 8'd0;
  logic       idelay_rst, idelay_ce, idelay_inc, bitslip;
  logic [4:0] tap_value;
  logic       data_aligned, align_fail, busy;
  logic [3:0] active_chan;
`ifdef ALIGN_DEBUG_EN
  logic [4:0] dbg_eye_start, dbg_eye_end;
  logic [3:0] dbg_slip_cnt;
`endif

  iodelay_bitslip_align dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_align_i  (start_align),
    .chan_sel_i     (chan_sel),
    .data_in_i      (data_in),
    .idelay_rst_o   (idelay_rst),
    .idelay_ce_o    (idelay_ce),
    .idelay_inc_o   (idelay_inc),
    .bitslip_o      (bitslip),
    .tap_value_o    (tap_value),
    .data_aligned_o (data_aligned),
    .align_fail_o   (align_fail),
    .busy_o         (busy),
    .active_chan_o  (active_chan)
`ifdef ALIGN_DEBUG_EN
    ,
    .eye_start_o    (dbg_eye_start),
    .eye_end_o      (dbg_eye_end),
    .slip_cnt_o     (dbg_slip_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int tap;
    int slips;
    int fail;
    int chan;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   fails = 0;

  // Channel model configuration
  int   eye_lo = 1, eye_hi = 0, need = 0, no_match = 0;
  int   m_tap = 0, m_slip = 0;
  logic [7:0] ctr = 8'd0;

  // Monitor state
  int   slips_seen = 0;
  int   overlap = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] word_for(input int tap, input int slips, input logic [7:0] noise);
    logic [7:0] w;
    int r;
    if (tap < eye_lo || tap > eye_hi) return noise;
    if (no_match != 0) return 8'hFF;
    w = 8'h2C;
    r = (need - slips) & 7;
    return (w << r) | (w >> (8 - r));
  endfunction

  // IODELAY / ISERDES model
  always @(posedge clk) begin
    if (idelay_rst) begin
      m_tap  <= 0;
      m_slip <= 0;
    end else if (idelay_ce && idelay_inc) begin
      m_tap <= m_tap + 1;
    end
    if (bitslip) m_slip <= m_slip + 1;
  end

  always @(negedge clk) begin
    ctr = ctr + 8'd1;
    data_in = word_for(m_tap, m_slip, ctr);
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      slips_seen = 0;
      overlap = 0;
    end else begin
      if (bitslip) slips_seen++;
      if (bitslip && idelay_ce) overlap = 1;
      if (data_aligned) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_data_aligned", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("tap_value", int'(tap_value), e.tap);
          chk("model_tap", m_tap, e.tap);
          chk("bitslip_count", slips_seen, e.slips);
          chk("align_fail", int'(align_fail), e.fail);
          chk("active_chan", int'(active_chan), e.chan);
          chk("busy_at_done", int'(busy), 1);
          chk("ce_bitslip_overlap", overlap, 0);
`ifdef ALIGN_DEBUG_EN
          chk("dbg_slip_cnt", int'(dbg_slip_cnt), e.slips);
`endif
        end
        slips_seen = 0;
        overlap = 0;
      end
    end
  end

  task automatic pulse_start(input int ch);
    @(negedge clk);
    chan_sel = 4'(ch);
    start_align = 1'b1;
    @(negedge clk);
    start_align = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb_q.size() != 0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("completion_timeout", 1, 0);
      sb_q.delete();
    end
    @(negedge clk);
    chk("busy_after_done", int'(busy), 0);
  endtask

  task automatic setup(input int lo, input int hi, input int nd, input int nm);
    eye_lo = lo;
    eye_hi = hi;
    need = nd;
    no_match = nm;
  endtask

  task automatic run(input int ch, input int etap, input int eslip, input int efail);
    exp_t e;
    e = '{etap, eslip, efail, ch};
    sb_q.push_back(e);
    pulse_start(ch);
    wait_done();
  endtask

  initial begin
    exp_t e;
    #1;
    chk("rst_tap_value", int'(tap_value), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_data_aligned", int'(data_aligned), 0);
    chk("rst_align_fail", int'(align_fail), 0);
    chk("rst_idelay_inc", int'(idelay_inc), 1);
    chk("rst_pulses", int'({idelay_rst, idelay_ce, bitslip}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: eye 10..20, 3 slips -> centre 15
    setup(10, 20, 3, 0);
    run(2, 15, 3, 0);

    // 2: never stable -> fail at end of sweep, no bitslips
    setup(1, 0, 0, 0);
    run(7, 31, 0, 1);

    // 3: eye ok, pattern never matches -> 8 slips then fail
    setup(10, 20, 0, 1);
    run(1, 15, 8, 1);

    // 4: all taps stable, already word-aligned -> centre 15, no slips
    setup(0, 31, 0, 0);
    run(4, 15, 0, 0);

    // 5: restart and chan_sel change while busy are ignored; eye 4..9 -> centre 6
    setup(4, 9, 1, 0);
    e = '{6, 1, 0, 5};
    sb_q.push_back(e);
    pulse_start(5);
    repeat (50) @(negedge clk);
    chk("busy_mid_run", int'(busy), 1);
    chan_sel = 4'd9;
    start_align = 1'b1;
    @(negedge clk);
    start_align = 1'b0;
    chk("chan_latched", int'(active_chan), 5);
    wait_done();

    // 6: reset mid-sweep aborts; next run starts cleanly from tap 0
    setup(10, 20, 3, 0);
    pulse_start(3);
    repeat (300) @(negedge clk);
    chk("pre_reset_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_tap_value", int'(tap_value), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_data_aligned", int'(data_aligned), 0);
    chk("abort_pulses", int'({idelay_rst, idelay_ce, bitslip}), 0);
    chk("abort_chan", int'(active_chan), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_abort", int'(busy), 0);
    e = '{15, 3, 0, 8};
    sb_q.push_back(e);
    pulse_start(8);
    repeat (3) @(negedge clk);
    chk("restart_model_tap0", m_tap, 0);
    chk("restart_tap_value0", int'(tap_value), 0);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
